paralelo_serial_tx: RTL

- Transmit-side serializer of the PHY link. It converts 8-bit parallel bytes into a 1-bit serial stream on clk_32f, most significant bit first.
- It sends the 8'hBC comma during link bring-up and whenever no data is valid, so the PHY receiver can detect commas and reach its active state.
- It sits between the byte-level transmit path (upstream) and the serial line to phy_rx (downstream).
- A free-running internal bit counter defines the byte slots, so no separate 4f clock is needed.

---
 rtl/paralelo_serial_tx.sv | 109 ++++++++++
 1 files changed

// File: rtl/paralelo_serial_tx.sv
// Transmit-side serializer: 8-bit bytes out MSB first on clk_32f, with comma-based
// link bring-up (OFF -> SYNC -> ACTIVE) framed by a free-running 3-bit bit counter.
module paralelo_serial_tx #(
   parameter logic [7:0]  COMMA      = 8'hBC,
   parameter int unsigned MIN_COMMAS = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       enable,
   input  logic       valid_in,
   input  logic [7:0] data_in,
   output logic       data_out,
   output logic       load,
   output logic       active,
   output logic       comma_err
);

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   localparam logic [3:0] MIN_CNT = 4'(MIN_COMMAS);

   state_t     state;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic [3:0] comma_cnt;
   logic [3:0] comma_inc;

   assign comma_inc = comma_cnt + 4'd1;
   assign data_out  = shreg[7];

   // Byte slots are framed purely by bit_cnt; every decision happens at bit_cnt==7.
   // NOTE: all state below uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_32f or negedge reset) begin
      if (!reset) begin
         bit_cnt   <= 3'd0;
         shreg     <= 8'h00;
         comma_cnt <= 4'd0;
         state     <= OFF;
         load      <= 1'b0;
         active    <= 1'b0;
         comma_err <= 1'b0;
      end else begin
         bit_cnt   <= bit_cnt + 3'd1;
         load      <= 1'b0;
         comma_err <= 1'b0;
         if (bit_cnt != 3'd7) begin
            shreg <= {shreg[6:0], 1'b0};
         end else begin
            case (state)
               OFF: begin
                  if (enable) begin
                     shreg     <= COMMA;
                     comma_cnt <= 4'd1;
                     if (MIN_CNT == 4'd1) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end else begin
                        state  <= SYNC;
                     end
                  end else begin
                     shreg <= 8'h00;
                  end
               end
               SYNC: begin
                  if (enable) begin
                     shreg     <= COMMA;
                     comma_cnt <= comma_inc;
                     if (comma_inc == MIN_CNT) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     shreg     <= 8'h00;
                     comma_cnt <= 4'd0;
                     state     <= OFF;
                  end
               end
               ACTIVE: begin
                  if (!enable) begin
                     shreg     <= 8'h00;
                     comma_cnt <= 4'd0;
                     state     <= OFF;
                     active    <= 1'b0;
                  end else if (valid_in) begin
                     // A data byte that looks like a comma is still sent, just flagged.
                     shreg     <= data_in;
                     load      <= 1'b1;
                     comma_err <= (data_in == COMMA);
                  end else begin
                     shreg <= COMMA;
                  end
               end
               default: begin
                  shreg     <= 8'h00;
                  comma_cnt <= 4'd0;
                  state     <= OFF;
                  active    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
